// File: rtl/ixc_sample_delta_fifo.sv
// Change-only capture of a sampled vector into a small first-word-fall-through FIFO.
// Each entry is {timestamp, value}. The host drains entries over o_valid/o_ready.
module ixc_sample_delta_fifo #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 16
) (
   input  logic                         fclk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [WIDTH-1:0]             sv,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [WIDTH-1:0]             o_data,
   output logic [TS_WIDTH-1:0]          o_ts,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         o_ovf,
   input  logic                         clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0]    mem_data_q [DEPTH];
   logic [TS_WIDTH-1:0] mem_ts_q   [DEPTH];

   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic                prime_q, prime_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                ovf_q, ovf_d;
   logic [WIDTH-1:0]    head_data_q, head_data_d;
   logic [TS_WIDTH-1:0] head_ts_q, head_ts_d;

   logic          push, pop, full, push_ok, ovf_set;
   logic [LW-1:0] remain;

   // Handshake: an entry transfers on any fclk edge where o_valid and o_ready are both 1;
   // o_data/o_ts stay stable while o_valid=1 and o_ready=0, and o_ready is ignored while o_valid=0.
   always_comb begin
      push        = en & (prime_q | (sv != prev_q));
      pop         = (level_q != '0) & o_ready;
      full        = (level_q == LW'(DEPTH));
      push_ok     = push & (~full | pop);
      ovf_set     = push & full & ~pop;

      ts_d        = ts_q;
      prev_d      = prev_q;
      prime_d     = 1'b1;
      if (en) begin
         ts_d    = ts_q + TS_WIDTH'(1);
         prev_d  = sv;
         prime_d = 1'b0;
      end

      wr_ptr_d    = wr_ptr_q + PW'(push_ok);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      remain      = level_q - LW'(pop);
      level_d     = remain + LW'(push_ok);
      ovf_d       = ovf_set | (ovf_q & ~clr_ovf);

      // Head is a registered copy: bypass the incoming sample when it lands in an empty FIFO.
      head_data_d = head_data_q;
      head_ts_d   = head_ts_q;
      if (push_ok && remain == '0) begin
         head_data_d = sv;
         head_ts_d   = ts_q;
      end else if (level_d != '0) begin
         head_data_d = mem_data_q[rd_ptr_d];
         head_ts_d   = mem_ts_q[rd_ptr_d];
      end
   end

   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         ts_q        <= '0;
         prev_q      <= '0;
         prime_q     <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
         head_data_q <= '0;
         head_ts_q   <= '0;
      end else begin
         ts_q        <= ts_d;
         prev_q      <= prev_d;
         prime_q     <= prime_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
         head_data_q <= head_data_d;
         head_ts_q   <= head_ts_d;
      end
   end

   // Storage needs no reset; occupancy alone decides which slots are live.
   always_ff @(posedge fclk) begin
      if (rst_n && push_ok) begin
         mem_data_q[wr_ptr_q] <= sv;
         mem_ts_q[wr_ptr_q]   <= ts_q;
      end
   end

   assign o_valid = (level_q != '0);
   assign o_data  = head_data_q;
   assign o_ts    = head_ts_q;
   assign level   = level_q;
   assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_ixc_sample_delta_fifo.sv
// Directed and random bench for ixc_sample_delta_fifo against a queue-based reference model.
module tb_ixc_sample_delta_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int TW = 4;
  localparam int LW = $clog2(D+1);

  logic            fclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [W-1:0]    sv = '0;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [W-1:0]    o_data;
  logic [TW-1:0]   o_ts;
  logic [LW-1:0]   level;
  logic            o_ovf;
  logic            clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 fclk = ~fclk;

  ixc_sample_delta_fifo #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TW)) dut (
    .fclk(fclk), .rst_n(rst_n), .en(en), .sv(sv),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ts(o_ts),
    .level(level), .o_ovf(o_ovf), .clr_ovf(clr_ovf)
  );

  // reference model: queue of {ts, value} entries
  logic [TW+W-1:0] exp_q[$];
  int              m_ts;
  logic [W-1:0]    m_prev;
  bit              m_prime;
  bit              m_ovf;
  logic [W-1:0]    m_last_d;
  logic [TW-1:0]   m_last_t;

  task automatic model_step(input bit r_n, input bit e, input logic [W-1:0] s,
                            input bit rdy, input bit c);
    bit pop, push, ovf_set;
    if (!r_n) begin
      exp_q.delete();
      m_ts = 0; m_prev = '0; m_prime = 1; m_ovf = 0;
      m_last_d = '0; m_last_t = '0;
      return;
    end
    pop     = (exp_q.size() != 0) && rdy;
    push    = e && (m_prime || s != m_prev);
    ovf_set = 0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < D) exp_q.push_back({TW'(m_ts), s});
      else ovf_set = 1;
    end
    m_ovf = ovf_set || (m_ovf && !c);
    if (e) begin
      m_prev  = s;
      m_prime = 0;
      m_ts    = (m_ts + 1) % (1 << TW);
    end else begin
      m_prime = 1;
    end
    if (exp_q.size() != 0) {m_last_t, m_last_d} = exp_q[0];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("valid", 64'(o_valid), 64'(exp_q.size() != 0));
    chk("ovf",   64'(o_ovf),   64'(m_ovf));
    chk("data",  64'(o_data),  64'(m_last_d));
    chk("ts",    64'(o_ts),    64'(m_last_t));
  endtask

  // driver: apply inputs, clock once, advance the model, check outputs #1 after the edge
  task automatic tick(input bit e, input logic [W-1:0] s, input bit rdy, input bit c);
    en = e; sv = s; o_ready = rdy; clr_ovf = c;
    @(posedge fclk);
    model_step(rst_n, e, s, rdy, c);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n, input logic [W-1:0] s);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick(1, s, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] v;

    // Reset with en=1 and all-ones sample: everything zero
    do_reset(3, 32'hFFFF_FFFF);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data), 64'd0);
    chk("rst_ts",    64'(o_ts), 64'd0);
    chk("rst_ovf",   64'(o_ovf), 64'd0);
    tick(1, 32'hFFFF_FFFF, 0, 0);
    chk("prime_level", 64'(level), 64'd1);
    chk("prime_data",  64'(o_data), 64'hFFFF_FFFF);
    chk("prime_ts",    64'(o_ts), 64'd0);

    // Constant input: one entry only
    do_reset(1, '0);
    for (int i = 0; i < 21; i++) tick(1, 32'h1234_5678, 0, 0);
    chk("const_level", 64'(level), 64'd1);
    chk("const_data",  64'(o_data), 64'h1234_5678);

    // Change sequence A,A,B,B,C drained immediately
    do_reset(1, '0);
    tick(1, 32'hAAAA_0001, 1, 0);
    chk("seq_a_ts", 64'(o_ts), 64'd0);
    chk("seq_a_d",  64'(o_data), 64'hAAAA_0001);
    tick(1, 32'hAAAA_0001, 1, 0);
    chk("seq_a_pop", 64'(o_valid), 64'd0);
    tick(1, 32'hBBBB_0002, 1, 0);
    chk("seq_b_ts", 64'(o_ts), 64'd2);
    chk("seq_b_d",  64'(o_data), 64'hBBBB_0002);
    tick(1, 32'hBBBB_0002, 1, 0);
    tick(1, 32'hCCCC_0003, 1, 0);
    chk("seq_c_ts", 64'(o_ts), 64'd4);
    chk("seq_c_d",  64'(o_data), 64'hCCCC_0003);
    tick(0, $urandom, 1, 0);

    // Overflow: toggle every cycle with no drain
    do_reset(1, '0);
    v = 32'h5555_5555;
    for (int i = 0; i < 10; i++) begin
      tick(1, v, 0, 0);
      v = ~v;
    end
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag",  64'(o_ovf), 64'd1);
    chk("ovf_head_ts", 64'(o_ts), 64'd0);
    tick(0, $urandom, 0, 1);
    chk("ovf_clr", 64'(o_ovf), 64'd0);
    // clear coinciding with a new overflow: set wins
    tick(1, v, 0, 1);
    chk("ovf_set_wins", 64'(o_ovf), 64'd1);
    tick(0, $urandom, 0, 1);
    // full with simultaneous push/pop
    for (int i = 0; i < 4; i++) begin
      v = ~v;
      tick(1, v, 1, 0);
      chk("full_pp_level", 64'(level), 64'd8);
      chk("full_pp_ovf", 64'(o_ovf), 64'd0);
    end
    for (int i = 0; i < 10; i++) tick(0, $urandom, 1, 0);
    chk("drain_empty", 64'(o_valid), 64'd0);

    // Enable gap and timestamp wrap
    do_reset(1, '0);
    for (int i = 0; i < 15; i++) tick(1, 32'h0000_00C3, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, $urandom, 0, 0);
    chk("gap_hold", 64'(o_valid), 64'd0);
    tick(1, 32'h0000_00C3, 0, 0);
    chk("gap_prime_ts", 64'(o_ts), 64'd15);
    tick(1, 32'h0000_00C4, 1, 0);
    chk("wrap_ts", 64'(o_ts), 64'd0);
    chk("wrap_d",  64'(o_data), 64'h0000_00C4);

    // Random traffic, occasional reset mid-drain
    do_reset(1, '0);
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      tick($urandom_range(0, 9) != 0, W'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ixc_sample_delta_fifo.md
Name: ixc_sample_delta_fifo

Overview:
- Downstream consumer of the 32-bit level sampler. It takes the sampled vector `sv` every `fclk` cycle and records only the changes.
- Each change is stored as a {timestamp, value} entry in a small FIFO. The host/trace uploader drains the FIFO over a valid/ready interface.
- Purpose: lets the emulation trace path keep only changed samples instead of streaming every cycle.

Parameters:
- `WIDTH`, 32: sampled vector width; must match the sampler output.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_WIDTH`, 16: free-running timestamp width.

Ports:
- `fclk`  input  1  sampling/fast clock; all logic rises on it.
- `rst_n`  input  1  synchronous active-low reset.
- `en`  input  1  capture enable.
- `sv`  input  WIDTH  sampled value from the sampler stage, valid every cycle.
- `o_valid`  output  1  head entry available.
- `o_ready`  input  1  consumer accepts head entry this cycle.
- `o_data`  output  WIDTH  head entry value.
- `o_ts`  output  TS_WIDTH  head entry timestamp.
- `level`  output  $clog2(DEPTH+1)  current occupancy.
- `o_ovf`  output  1  sticky overflow flag.
- `clr_ovf`  input  1  clears `o_ovf`.

Behaviour:
- Reset (`rst_n`=0 sampled at a `fclk` edge):
  - `o_valid`=0, `level`=0, `o_ovf`=0.
  - `o_data`=0, `o_ts`=0.
  - Timestamp counter=0, prev register=0, prime flag=1.
  - FIFO pointers=0.
  - A reset mid-drain discards all entries with no partial output.
- Timestamp counter:
  - Increments by 1 each cycle `en`=1 and wraps modulo 2^TS_WIDTH.
  - Holds while `en`=0.
  - The stored timestamp is the counter value in the capture cycle, before increment.
- Capture condition, evaluated each cycle with `en`=1:
  - push = prime | (`sv` != prev).
  - prev <= `sv` every `en` cycle.
  - prime <= 0 after any `en` cycle.
  - While `en`=0: prev holds, no push, and prime <= 1. The first sample after `en` re-asserts is therefore always captured.
- FIFO behaviour:
  - First-word-fall-through, registered storage.
  - A push in cycle N makes the entry visible at the head (`o_valid`=1, `o_data`/`o_ts` updated) in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
  - Pop occurs when `o_valid` & `o_ready`.
  - `o_data`/`o_ts` are stable while `o_valid`=1 and `o_ready`=0.
  - `o_data`/`o_ts` are don't-care when `o_valid`=0. The implementation holds their last value.
- Simultaneous push and pop:
  - Allowed at any level, including full; `level` is unchanged.
  - When full, the pop frees a slot, so the push is accepted with no overflow.
- Full without pop:
  - A push is dropped; the FIFO contents are unchanged.
  - `o_ovf` <= 1 next cycle.
  - prev still updates, so the next entry reflects the next change, not the dropped one.
- Empty:
  - `o_ready` with `o_valid`=0 has no effect.
  - `level` never underflows.
- `o_ovf`:
  - Sticky; cleared by `clr_ovf`=1.
  - If `clr_ovf` and a new overflow coincide, the set wins and `o_ovf` stays 1.
- `level`:
  - Registered; equals pushes minus pops since reset.
  - Ranges 0..DEPTH.
  - `o_valid` = (`level` != 0).
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `level`.
- X on `sv` when `en`=0 must not propagate to any state.

Test Plan:
- Reset: hold `rst_n`=0 for 3 cycles with `sv`=32'hFFFF_FFFF and `en`=1 -> all outputs 0. On release, the first `en` cycle captures {ts=0, 32'hFFFF_FFFF}, visible 1 cycle later with `level`=1.
- Constant input: `en`=1, `sv` constant 32'h1234_5678 for 20 cycles after the prime capture -> exactly one entry; `level` stays 1.
- Change sequence: `sv` = A,A,B,B,C from ts 0, with `o_ready`=1 -> entries {0,A}, {2,B}, {4,C} in order, each 1 cycle after its capture.
- Overflow: `o_ready`=0, `sv` toggles every cycle for 10 cycles, `DEPTH`=8 -> `level`=8, entries ts 0..7, `o_ovf`=1. Pulse `clr_ovf` -> `o_ovf`=0. Entries are intact on drain.
- Full with simultaneous push/pop: at `level`=8, toggle `sv` with `o_ready`=1 -> `level` stays 8, no overflow, and the new entry is at the tail.
- Enable gap and wrap:
  - `TS_WIDTH`=4; run 15 cycles, drop `en` for 3 cycles (counter holds, no pushes), then re-assert with unchanged `sv` -> prime capture at ts=15.
  - The next change is captured at ts=0 after the wrap.
